slip_sched_rx: RTL
==================

# slip_sched_rx

Shared slip scheduler for the multi-lane receive PCS. It collects per-lane slip requests from the block-sync units and serialises them onto the shared gearbox/SerDes bitslip control, one lane at a time, in round-robin order. After each slip it enforces a settle holdoff so the gearbox realignment takes effect before another slip is issued. It also qualifies the per-lane lock flags into one debounced all-lanes-locked status for the alignment-marker and deskew logic.

## Interface
- `LANE_N`, 4: number of PCS lanes; must be ≥ 2.
- `HOLD_N`, 32: settle cycles after each slip pulse; must be ≥ 1.
- `LOCK_N`, 16: consecutive cycles all lanes must be locked before `all_lock_o` rises.
- `clk`  in  1  single clock for all logic.
- `nreset`  in  1  asynchronous, active-low reset.
- `slip_req_i`  in  LANE_N  per-lane slip pulse from block sync (`slip_v_o`).
- `lock_i`  in  LANE_N  per-lane block lock (`lock_v_o`).
- `slip_o`  out  LANE_N  one-hot, single-cycle bitslip command to the gearbox lane.
- `busy_o`  out  LANE_N  lane has a pending request or is in SLIP/HOLD.
- `all_lock_o`  out  1  all lanes locked for `LOCK_N` consecutive cycles.

## Operation
- Per-lane `pending` register:
  - Set on `slip_req_i[i]`.
  - Cleared on the edge where lane i is granted.
  - A request is ignored if lane i is already pending, is the active lane in SLIP/HOLD, or is being granted on that edge.
- The FSM has three states: IDLE, SLIP and HOLD. It is one-hot.
  - IDLE → SLIP when any `pending` bit is set. The grant is latched into `active` and `pending[grant]` is cleared.
  - SLIP → HOLD always, after one cycle. `slip_o` equals `active` during SLIP and is 0 in every other state.
  - In HOLD, `hold_cnt` loads `HOLD_N-1` on entry and decrements each cycle.
  - When `hold_cnt` reaches 0: go to SLIP with a new grant if any lane is pending, otherwise go to IDLE.
- Arbitration is round-robin:
  - Priority pointer `ptr` resets to lane 0.
  - On each grant, `ptr` becomes `(grant+1) mod LANE_N`.
  - The first pending lane at or after `ptr`, wrapping, wins.
- `busy_o[i] = pending[i] | (active_onehot[i] & (SLIP|HOLD))`.
- Lock qualifier:
  - Counter `lock_cnt`, width `$clog2(LOCK_N+1)`, saturating at `LOCK_N`.
  - Counts while `&lock_i`. Clears to 0 on any cycle where any `lock_i` bit is low.
  - `all_lock_o` is registered as `lock_cnt == LOCK_N`.
- Slips do not touch `lock_cnt` directly. Lock loss arrives through `lock_i`.

## Timing
- Reset values:
  - FSM in IDLE; `pending`, `active`, `hold_cnt`, `lock_cnt` = 0; `ptr` = 0.
  - `slip_o` = 0, `busy_o` = 0, `all_lock_o` = 0.
  - All outputs are registered, so each output holds its reset value until the first edge after reset release.
- Request to slip latency: a request sampled at edge t makes `pending` visible from cycle t+1. If the FSM is IDLE, `slip_o` is high in cycle t+2.
- Slip spacing: consecutive `slip_o` pulses are at least `HOLD_N+1` cycles apart.
- `busy_o[i]` rises the cycle after the request. It falls the cycle after HOLD ends for that lane.
- Lock timing: `all_lock_o` rises `LOCK_N+1` cycles after the first cycle of `&lock_i`. It falls the cycle after any `lock_i` drops.
- Reset asserted mid-operation, including mid-SLIP or mid-HOLD: all state clears immediately and `slip_o` drops without waiting for a clock. Pending requests are lost.

## Structure
- `LANE_N` default and the lane count constant live in the shared PCS package with the other 40GBASE-R lane constants.
- The round-robin arbiter is a natural sub-module, `rr_arb`:
  - Parameter `N`.
  - Inputs `req[N]` and `ptr`.
  - Output one-hot `grant[N]`.
  - Purely combinational. `ptr` is kept in the parent.

## Test plan
All scenarios use `LANE_N=4`, `HOLD_N=8`, `LOCK_N=16`.
- Reset: `nreset` low, inputs toggling → all outputs 0 during reset and on the first cycle after release.
- Single request: `slip_req_i=4'b0100` at cycle 10 →
  - `slip_o=4'b0100` in cycle 12 only.
  - `busy_o[2]` high in cycles 11–20.
- Simultaneous requests: `slip_req_i=4'b1011` at cycle 10 →
  - `slip_o` = 0001 @12, 0010 @21, 1000 @30.
  - No other pulses.
- Fairness and merge:
  - Lane 0 requests every cycle from 10; lane 1 requests once at 10 → grants alternate 0, 1, 0 (@12, @21, @30).
  - Lane 0 requests during its own HOLD are dropped, with no extra pulse.
- Reset mid-HOLD: `nreset` low at cycle 15 with lane 3 pending →
  - All outputs 0 asynchronously.
  - After release, no `slip_o` without a new request.
- Lock qualify:
  - `lock_i=4'hF` from cycle 5 → `all_lock_o` high from cycle 22.
  - `lock_i[1]` low at cycle 30 → `all_lock_o` low from cycle 31.
  - `lock_i` back to `4'hF` at 32 → high again at 49.

Source files
------------

// File: rtl/slip_sched_rx_pkg.sv
// Shared PCS receive constants and slip scheduler types.
// Lane count and scheduler defaults for the 40GBASE-R receive path.
package slip_sched_rx_pkg;

  localparam int PCS_LANE_N = 4;
  localparam int PCS_HOLD_N = 32;
  localparam int PCS_LOCK_N = 16;

  localparam int ST_IDLE_B = 0;
  localparam int ST_SLIP_B = 1;
  localparam int ST_HOLD_B = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_SLIP = 3'b010,
    ST_HOLD = 3'b100
  } sched_st_e;

endpackage

// File: rtl/slip_sched_rx_rr_arb.sv
// Round-robin one-hot arbiter for the slip scheduler.
// The first request at or after ptr, wrapping, wins.
module rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  logic [2*N-1:0] dbl_req;
  logic [2*N-1:0] dbl_gnt;
  logic [N-1:0]   rot_req;
  logic [N-1:0]   rot_gnt;

  // rotate so ptr is bit 0, take lowest set bit, rotate back
  always_comb begin
    dbl_req = {req, req} >> ptr;
    rot_req = dbl_req[N-1:0];
    rot_gnt = rot_req & (~rot_req + N'(1));
    dbl_gnt = {rot_gnt, rot_gnt} << ptr;
    grant   = dbl_gnt[2*N-1:N];
  end

endmodule

// File: rtl/slip_sched_rx.sv
// Shared bitslip scheduler and all-lanes-lock qualifier.
// Serialises per-lane slip requests with a settle holdoff.
module slip_sched_rx
  import slip_sched_rx_pkg::*;
#(
  parameter int LANE_N = PCS_LANE_N,
  parameter int HOLD_N = PCS_HOLD_N,
  parameter int LOCK_N = PCS_LOCK_N
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [LANE_N-1:0] slip_req_i,
  input  logic [LANE_N-1:0] lock_i,
  output logic [LANE_N-1:0] slip_o,
  output logic [LANE_N-1:0] busy_o,
  output logic              all_lock_o
);

  localparam int PW = $clog2(LANE_N);
  localparam int HW = (HOLD_N > 1) ? $clog2(HOLD_N) : 1;
  localparam int LW = $clog2(LOCK_N + 1);

  localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD_N - 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_N);

  sched_st_e         state_q, state_d;
  logic [LANE_N-1:0] pending_q, pending_d;
  logic [LANE_N-1:0] active_q, active_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
  logic [LANE_N-1:0] slip_q, slip_d;
  logic [LANE_N-1:0] busy_q, busy_d;
  logic              all_lock_q, all_lock_d;

  logic [LANE_N-1:0] grant;
  logic [LANE_N-1:0] gnt_m;
  logic [LANE_N-1:0] act_m;
  logic              do_grant;
  logic              in_win_d;

  rr_arb #(
    .N(LANE_N)
  ) u_arb (
    .req  (pending_q),
    .ptr  (ptr_q),
    .grant(grant)
  );

  // FSM next state, grant bookkeeping and pending update
  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    hold_cnt_d = hold_cnt_q;
    ptr_d      = ptr_q;
    do_grant   = 1'b0;
    unique case (1'b1)
      state_q[ST_IDLE_B]: begin
        if (|pending_q) do_grant = 1'b1;
      end
      state_q[ST_SLIP_B]: begin
        state_d    = ST_HOLD;
        hold_cnt_d = HOLD_LD;
      end
      state_q[ST_HOLD_B]: begin
        if (hold_cnt_q == '0) begin
          if (|pending_q) do_grant = 1'b1;
          else state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - HW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    gnt_m = do_grant ? grant : '0;
    if (do_grant) begin
      state_d  = ST_SLIP;
      active_d = grant;
      for (int k = 0; k < LANE_N; k++) begin
        if (grant[k]) ptr_d = PW'((k + 1) % LANE_N);
      end
    end

    act_m = (state_q[ST_SLIP_B] | state_q[ST_HOLD_B])
          ? active_q : '0;
    pending_d = (pending_q | (slip_req_i & ~act_m)) & ~gnt_m;

    in_win_d = state_d[ST_SLIP_B] | state_d[ST_HOLD_B];
    slip_d   = state_d[ST_SLIP_B] ? active_d : '0;
    busy_d   = pending_d | (in_win_d ? active_d : '0);
  end

  // lock run counter, saturating at LOCK_N
  always_comb begin
    lock_cnt_d = '0;
    if (&lock_i) begin
      lock_cnt_d = (lock_cnt_q == LOCK_MAX)
                 ? LOCK_MAX : lock_cnt_q + LW'(1);
    end
    all_lock_d = (lock_cnt_q == LOCK_MAX) & (&lock_i);
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      active_q   <= '0;
      hold_cnt_q <= '0;
      ptr_q      <= '0;
      lock_cnt_q <= '0;
      slip_q     <= '0;
      busy_q     <= '0;
      all_lock_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      active_q   <= active_d;
      hold_cnt_q <= hold_cnt_d;
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
      slip_q     <= slip_d;
      busy_q     <= busy_d;
      all_lock_q <= all_lock_d;
    end
  end

  assign slip_o     = slip_q;
  assign busy_o     = busy_q;
  assign all_lock_o = all_lock_q;

endmodule
